// File: rtl/uart_packet_framer.sv
// uart_packet_framer: hunts for a start byte in the received UART byte
// stream, collects a fixed-length payload plus an XOR checksum, and
// releases the payload on a valid/ready stream only if the checksum matches.
module uart_packet_framer #(
  parameter logic [7:0]  START_BYTE     = 8'hED,
  parameter int          PAYLOAD_LEN    = 4,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       packet,
  output logic       err_checksum,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic       busy
);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;
  localparam logic [1:0] SEND    = 2'd3;

  localparam logic [3:0]  LEN_IDX  = 4'(PAYLOAD_LEN);
  localparam logic [3:0]  LAST_IDX = 4'(PAYLOAD_LEN - 1);
  localparam logic [19:0] TO_LAST  = TIMEOUT_CYCLES - 20'd1;

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [3:0]  out_idx;
  logic [7:0]  chk;
  logic [7:0]  chk_rx;
  logic [19:0] tcnt;
  logic [19:0] tcnt_inc;
  logic        store_byte;
  // 16 entries so the 4-bit index covers the array exactly
  logic [7:0]  pbuf [16];

  // Saturating increment: the idle counter must never wrap back to 0
  function automatic logic [19:0] sat_inc(input logic [19:0] v);
    sat_inc = (v == 20'hFFFFF) ? v : v + 20'd1;
  endfunction

  // Idle-count next value and payload write enable
  always_comb begin
    tcnt_inc   = sat_inc(tcnt);
    store_byte = (state == COLLECT) && s_valid && (idx != LEN_IDX);
  end

  // Frame state machine, counters, running checksum and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      idx          <= 4'd0;
      out_idx      <= 4'd0;
      chk          <= 8'h00;
      chk_rx       <= 8'h00;
      tcnt         <= 20'd0;
      packet       <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      packet       <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
      case (state)
        HUNT: begin
          if (s_valid && (s_data == START_BYTE)) begin
            state <= COLLECT;
            idx   <= 4'd0;
            chk   <= 8'h00;
            tcnt  <= 20'd0;
          end
        end
        COLLECT: begin
          if (s_valid) begin
            // a byte in the expiry cycle wins over the timeout
            tcnt <= 20'd0;
            if (idx == LEN_IDX) begin
              chk_rx <= s_data;
              state  <= CHECK;
            end else begin
              chk <= chk ^ s_data;
              idx <= idx + 4'd1;
            end
          end else if (tcnt_inc == TO_LAST) begin
            err_timeout <= 1'b1;
            state       <= HUNT;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        CHECK: begin
          err_overrun <= s_valid;
          if (chk_rx == chk) begin
            state   <= SEND;
            packet  <= 1'b1;
            out_idx <= 4'd0;
          end else begin
            err_checksum <= 1'b1;
            state        <= HUNT;
          end
        end
        SEND: begin
          // no backpressure upstream: anything arriving now is lost
          err_overrun <= s_valid;
          if (m_ready) begin
            if (out_idx == LAST_IDX) begin
              state <= HUNT;
            end else begin
              out_idx <= out_idx + 4'd1;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  // Payload storage is pure data and needs no reset
  always_ff @(posedge clk) begin
    if (store_byte) begin
      pbuf[idx] <= s_data;
    end
  end

  // Release stream is decoded from state so reset forces it to zero at once
  always_comb begin
    m_valid = (state == SEND);
    m_data  = m_valid ? pbuf[out_idx] : 8'h00;
    m_last  = m_valid && (out_idx == LAST_IDX);
    busy    = (state != HUNT);
  end

endmodule

// File: tb/tb_uart_packet_framer.sv
// Scoreboard bench for uart_packet_framer: the stimulus process pushes the
// expected released bytes, a negedge monitor pops and compares them and
// counts status pulses; the stimulus process checks pulse counts/timing.
module tb_uart_packet_framer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       m_ready = 1'b1;
  logic       m_valid, m_last, packet, err_checksum, err_timeout, err_overrun, busy;
  logic [7:0] m_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int pkt_n = 0, ck_n = 0, to_n = 0, ov_n = 0, mv_n = 0;
  int last_pkt_cyc = -1, last_to_cyc = -1, last_acc_cyc = -1;

  logic [8:0] exp_q[$];
  logic       prev_hold = 1'b0;
  logic [8:0] prev_out = 9'h000;

  uart_packet_framer #(
    .START_BYTE(8'hED),
    .PAYLOAD_LEN(4),
    .TIMEOUT_CYCLES(20'd100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_valid(s_valid),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_last(m_last),
    .m_ready(m_ready),
    .packet(packet),
    .err_checksum(err_checksum),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  wire [13:0] outs = {m_valid, m_data, m_last, packet, err_checksum,
                      err_timeout, err_overrun, busy};

  // Monitor: scoreboard pop on each accepted byte, hold check, pulse counting
  always @(negedge clk) begin
    if (prev_hold && m_valid) begin
      vectors++;
      if ({m_last, m_data} !== prev_out) begin
        miscompares++;
        $display("FAIL hold_stable: got %h expected %h", {m_last, m_data}, prev_out);
      end
    end
    if (m_valid && m_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_byte: got %h expected none", {m_last, m_data});
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({m_last, m_data} !== e) begin
          miscompares++;
          $display("FAIL stream_byte: got last/data %h expected %h", {m_last, m_data}, e);
        end
      end
      last_acc_cyc = cyc;
    end
    prev_hold = m_valid && !m_ready && !reset;
    prev_out  = {m_last, m_data};
    if (m_valid)      mv_n++;
    if (packet)       begin pkt_n++; last_pkt_cyc = cyc; end
    if (err_checksum) ck_n++;
    if (err_timeout)  begin to_n++; last_to_cyc = cyc; end
    if (err_overrun)  ov_n++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All drive tasks start and end at #1 after a rising edge
  task automatic put(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b0, b});
    exp_q.push_back({1'b0, c});
    exp_q.push_back({1'b1, d});
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input logic [7:0] k);
    put(8'hED); put(a); put(b); put(c); put(d); put(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, c0, t0, o0, mv0, e;
    idle(3);
    check("reset_outputs", 32'(outs), 32'h0);
    reset = 1'b0;
    idle(2);

    // Good frame, leading 0x55 ignored; CHK = 01^02^03^04 = 04
    p0 = pkt_n;
    put(8'h55);
    check("busy_after_noise", 32'(busy), 32'h0);
    push_exp(8'h01, 8'h02, 8'h03, 8'h04);
    frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    e = cyc;
    idle(8);
    check("good_packet_count", 32'(pkt_n - p0), 32'd1);
    check("good_packet_cycle", 32'(last_pkt_cyc), 32'(e + 1));
    check("good_last_accept_cycle", 32'(last_acc_cyc), 32'(e + 4));
    check("good_busy_after", 32'(busy), 32'h0);

    // Bad checksum, then a frame with START_BYTE inside the payload
    p0 = pkt_n; c0 = ck_n; mv0 = mv_n;
    frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
    idle(4);
    check("badck_err_count", 32'(ck_n - c0), 32'd1);
    check("badck_no_mvalid", 32'(mv_n - mv0), 32'd0);
    check("badck_busy_after", 32'(busy), 32'h0);
    push_exp(8'hED, 8'h00, 8'hFF, 8'h12);
    frame(8'hED, 8'h00, 8'hFF, 8'h12, 8'h00);
    idle(8);
    check("badck_next_packet", 32'(pkt_n - p0), 32'd1);

    // Timeout: expiry decided on the 99th edge after byte 01
    t0 = to_n;
    put(8'hED); put(8'h01);
    e = cyc;
    idle(100);
    check("timeout_count", 32'(to_n - t0), 32'd1);
    check("timeout_cycle", 32'(last_to_cyc), 32'(e + 99));
    check("timeout_busy_after", 32'(busy), 32'h0);

    // Byte exactly at the expiry cycle keeps the frame alive
    t0 = to_n; p0 = pkt_n;
    push_exp(8'h01, 8'h02, 8'h03, 8'h04);
    put(8'hED); put(8'h01);
    idle(98);
    put(8'h02); put(8'h03); put(8'h04); put(8'h04);
    idle(8);
    check("late_byte_no_timeout", 32'(to_n - t0), 32'd0);
    check("late_byte_packet", 32'(pkt_n - p0), 32'd1);

    // Backpressure on the second byte plus an injected START_BYTE
    p0 = pkt_n; o0 = ov_n; c0 = ck_n; t0 = to_n;
    push_exp(8'h01, 8'h02, 8'h03, 8'h04);
    frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    idle(2);
    m_ready = 1'b0;
    put(8'hED);
    check("stall_data", 32'({m_valid, m_data}), 32'h102);
    idle(9);
    check("stall_data_end", 32'({m_valid, m_data}), 32'h102);
    m_ready = 1'b1;
    idle(6);
    check("overrun_count", 32'(ov_n - o0), 32'd1);
    check("overrun_packet_count", 32'(pkt_n - p0), 32'd1);
    check("overrun_no_frame", 32'(busy), 32'h0);
    check("overrun_no_other_err", 32'((ck_n - c0) + (to_n - t0)), 32'd0);

    // Reset mid-collect and mid-send
    p0 = pkt_n; c0 = ck_n; t0 = to_n; o0 = ov_n;
    put(8'hED); put(8'h01); put(8'h02);
    #2 reset = 1'b1;
    #1 check("reset_collect_outs", 32'(outs), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    m_ready = 1'b0;
    frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    idle(2);
    check("send_before_reset", 32'({m_valid, m_data}), 32'h101);
    #2 reset = 1'b1;
    #1 check("reset_send_outs", 32'(outs), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    m_ready = 1'b1;
    idle(3);
    check("reset_pulses", 32'((ck_n - c0) + (to_n - t0) + (ov_n - o0)), 32'd0);
    check("reset_packet_count", 32'(pkt_n - p0), 32'd1);
    push_exp(8'hA5, 8'h5A, 8'hC3, 8'h3C);
    frame(8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h00);
    idle(8);
    check("post_reset_packet", 32'(pkt_n - p0), 32'd2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
